mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port to one-port memory arbiter for the pipelined core. It shares a single unified memory bus between the instruction-fetch port (read-only, driven from the Fetch stage PC) and the data port (load/store, driven from the Memory stage ALUResultM/WriteDataM/MemWriteSelect). It also generates the fetch and memory stall requests that the hazard unit consumes. It sits between the datapath and the external memory model/controller.

## Interface
Parameters:
- XLEN, 32: address/data width.
- STARVE_LIMIT, 4: consecutive data-over-fetch wins, with fetch pending, before fetch is forced priority; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_done or if_flush.
- if_addr  in  XLEN  fetch address; stable while if_req is high.
- if_flush  in  1  one-cycle pulse; discards the outstanding or pending fetch.
- if_done  out  1  fetch complete; if_rdata valid this cycle.
- if_rdata  out  XLEN  fetched instruction.
- d_req  in  1  data request; held until d_done; must never be withdrawn early.
- d_we  in  1  1 = store, 0 = load.
- d_wstrb  in  4  byte-write strobes (MemWriteSelect).
- d_addr  in  XLEN  data address.
- d_wdata  in  XLEN  store data.
- d_done  out  1  data access complete.
- d_rdata  out  XLEN  load data.
- mem_req  out  1  memory transaction valid; registered.
- mem_we  out  1  registered write enable.
- mem_wstrb  out  4  registered strobes; 0 for fetch and loads.
- mem_addr  out  XLEN  registered address.
- mem_wdata  out  XLEN  registered write data.
- mem_rdata  in  XLEN  memory read data; valid when mem_ack is high.
- mem_ack  in  1  one-cycle completion pulse from memory.
- stall_if  out  1  if_req & ~if_done.
- stall_mem  out  1  d_req & ~d_done.

## Operation
- States: IDLE, BUSY_I, BUSY_D.
- IDLE, only d_req: go to BUSY_D. Only if_req and no if_flush: go to BUSY_I. Both requests: data wins unless starve_cnt == STARVE_LIMIT, in which case fetch wins. Neither request: stay in IDLE.
- On a grant, latch the address, we, wstrb and wdata into the mem_* registers and set mem_req=1. For a fetch grant, mem_we=0 and mem_wstrb=0.
- BUSY_x holds mem_* stable until mem_ack. On mem_ack, clear mem_req and return to IDLE.
- Completion outputs are combinational:
  - d_done = mem_ack & BUSY_D.
  - if_done = mem_ack & BUSY_I & ~discard & ~if_flush.
  - if_rdata and d_rdata are both mem_rdata.
- discard flag:
  - Set by if_flush while in BUSY_I.
  - Cleared on leaving BUSY_I.
  - A discarded fetch still completes on the memory bus, but no if_done is produced.
- if_flush in IDLE suppresses a fetch grant that cycle only.
- A req that is high on the edge where its done=1 is consumed. A req that is high in the following IDLE cycle is a new request.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) when data is granted while if_req is high.
  - Clears on any fetch grant.
  - Holds otherwise.
- mem_ack in IDLE is ignored (protocol error; no state change).

## Timing
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, starve_cnt=0, discard=0. All done and stall outputs follow from these values.
- Reset asserted mid-transaction: go to IDLE immediately and drop mem_req asynchronously. The memory side must tolerate the abandoned transaction.
- Latency:
  - Request sampled at edge N gives mem_req high in cycle N+1.
  - A zero-wait memory acks in cycle N+1, so done is in cycle N+1.
  - Minimum of 2 cycles per access, including one IDLE turnaround cycle between transactions.
- Simultaneous if_flush and mem_ack in BUSY_I: the fetch is discarded and if_done=0.
- Simultaneous d_req and if_req at reset release: data is granted first and starve_cnt becomes 1.

## Test plan
- Single fetch:
  - Stimulus: if_req=1, if_addr=0x100, memory acks 2 cycles after mem_req with mem_rdata=0x00500093.
  - Response: mem_addr=0x100, mem_we=0, if_done=1 for exactly one cycle with if_rdata=0x00500093, stall_if high until that cycle.
- Store over pending fetch:
  - Stimulus: d_req (we=1, wstrb=0x3, addr=0x2000, wdata=0xBEEF) and if_req asserted in the same cycle.
  - Response: BUSY_D first with mem_wstrb=0x3; the fetch is granted in the IDLE cycle after d_done.
- Starvation:
  - Stimulus: if_req held high while d_req is re-asserted after every d_done, STARVE_LIMIT=4.
  - Response: 4 data grants, then a fetch grant, then starve_cnt=0.
- Flush mid-fetch:
  - Stimulus: if_flush pulsed in cycle 1 of a 3-cycle fetch to 0x40.
  - Response: mem_req stays high until mem_ack, if_done never asserts, and the next fetch to 0x80 is granted after IDLE.
- Flush coincident with ack:
  - Stimulus: if_flush and mem_ack in the same cycle.
  - Response: if_done=0 and the state returns to IDLE.
- Reset mid-store:
  - Stimulus: assert reset while in BUSY_D.
  - Response: mem_req=0 and all mem_* outputs=0 without waiting for a clock edge, state IDLE, and no d_done.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one memory bus between the instruction-fetch port and the load/store port.
// Data normally wins; a starvation counter forces fetch priority after STARVE_LIMIT data wins.
module mem_arbiter #(
   parameter int XLEN         = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            if_req,
   input  logic [XLEN-1:0] if_addr,
   input  logic            if_flush,
   output logic            if_done,
   output logic [XLEN-1:0] if_rdata,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [3:0]      d_wstrb,
   input  logic [XLEN-1:0] d_addr,
   input  logic [XLEN-1:0] d_wdata,
   output logic            d_done,
   output logic [XLEN-1:0] d_rdata,
   output logic            mem_req,
   output logic            mem_we,
   output logic [3:0]      mem_wstrb,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_ack,
   output logic            stall_if,
   output logic            stall_mem,
   output logic [1:0]      o_dbg_state,
   output logic [3:0]      o_dbg_starve_cnt
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   // Handshake: a requester holds req (and its address/data) stable until the
   // matching done pulse; the memory holds nothing and answers a registered
   // mem_req with exactly one mem_ack cycle.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   state_t     r_state;
   logic [3:0] r_starve_cnt;
   logic       r_discard;

   logic w_idle;
   logic w_fetch_cand;
   logic w_starved;
   logic w_grant_i;
   logic w_grant_d;

   assign w_idle       = (r_state == IDLE);
   assign w_fetch_cand = if_req & ~if_flush;
   assign w_starved    = (r_starve_cnt == LIMIT);
   assign w_grant_i    = w_idle & w_fetch_cand & (~d_req | w_starved);
   assign w_grant_d    = w_idle & d_req & ~w_grant_i;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_starve_cnt <= 4'd0;
         r_discard    <= 1'b0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_wstrb    <= 4'h0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               // Fetch grants carry no write payload, so wdata is zeroed too.
               if (w_grant_i) begin
                  r_state      <= BUSY_I;
                  r_starve_cnt <= 4'd0;
                  mem_req      <= 1'b1;
                  mem_we       <= 1'b0;
                  mem_wstrb    <= 4'h0;
                  mem_addr     <= if_addr;
                  mem_wdata    <= '0;
               end else if (w_grant_d) begin
                  r_state   <= BUSY_D;
                  mem_req   <= 1'b1;
                  mem_we    <= d_we;
                  mem_wstrb <= d_we ? d_wstrb : 4'h0;
                  mem_addr  <= d_addr;
                  mem_wdata <= d_wdata;
                  if (if_req && (r_starve_cnt < LIMIT)) begin
                     r_starve_cnt <= r_starve_cnt + 4'd1;
                  end
               end
            end
            BUSY_I: begin
               if (mem_ack) begin
                  r_state   <= IDLE;
                  mem_req   <= 1'b0;
                  r_discard <= 1'b0;
               end else if (if_flush) begin
                  r_discard <= 1'b1;
               end
            end
            BUSY_D: begin
               if (mem_ack) begin
                  r_state <= IDLE;
                  mem_req <= 1'b0;
               end
            end
            default: begin
               r_state   <= IDLE;
               mem_req   <= 1'b0;
               r_discard <= 1'b0;
            end
         endcase
      end
   end

   // A flushed fetch still finishes on the bus but never reaches the core.
   assign d_done  = mem_ack & (r_state == BUSY_D);
   assign if_done = mem_ack & (r_state == BUSY_I) & ~r_discard & ~if_flush;

   assign if_rdata  = mem_rdata;
   assign d_rdata   = mem_rdata;
   assign stall_if  = if_req & ~if_done;
   assign stall_mem = d_req & ~d_done;

   assign o_dbg_state      = r_state;
   assign o_dbg_starve_cnt = r_starve_cnt;

`ifndef SYNTHESIS
   a_req_matches_state : assert property (@(posedge clk) disable iff (!reset)
      mem_req == (r_state != IDLE));
   a_starve_in_range : assert property (@(posedge clk) disable iff (!reset)
      r_starve_cnt <= LIMIT);
   a_discard_only_in_fetch : assert property (@(posedge clk) disable iff (!reset)
      r_discard |-> (r_state == BUSY_I));
   a_bus_stable : assert property (@(posedge clk) disable iff (!reset)
      ((r_state != IDLE) && !mem_ack) |=> ($stable(mem_addr) && $stable(mem_wdata)
                                           && $stable(mem_wstrb) && $stable(mem_we)));
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios pinned with literal values, then random
// traffic checked every cycle against a transaction-level model of the shared bus.
module tb_mem_arbiter;

   localparam int XLEN  = 32;
   localparam int LIMIT = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            if_req, if_flush, d_req, d_we, mem_ack;
   logic [XLEN-1:0] if_addr, d_addr, d_wdata, mem_rdata;
   logic [3:0]      d_wstrb;
   logic            if_done, d_done, mem_req, mem_we, stall_if, stall_mem;
   logic [XLEN-1:0] if_rdata, d_rdata, mem_addr, mem_wdata;
   logic [3:0]      mem_wstrb, dbg_starve;
   logic [1:0]      dbg_state;

   always #5 clk = ~clk;

   mem_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_done(if_done), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .stall_if(stall_if), .stall_mem(stall_mem),
      .o_dbg_state(dbg_state), .o_dbg_starve_cnt(dbg_starve)
   );

   int checks_total = 0;
   int checks_pass  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks_total++;
      if (act === exp) checks_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Model of the bus: at most one transaction in flight, described by its owner
   // and payload; m_wins counts data wins while a fetch was waiting.
   bit              m_busy, m_is_fetch, m_cancel;
   int              m_wins;
   logic [XLEN-1:0] m_addr, m_wdata;
   logic            m_we;
   logic [3:0]      m_wstrb;

   int              wait_cnt, mem_lat;
   logic [XLEN-1:0] ack_data;
   bit              spurious_en;

   logic            s_mem_req, s_if_done, s_d_done, s_mem_we;
   logic [XLEN-1:0] s_mem_addr, s_if_rdata;
   logic [3:0]      s_mem_wstrb, s_starve;
   logic [1:0]      s_state;
   bit              ev_if_done, ev_d_done;

   task automatic model_reset();
      m_busy = 0; m_is_fetch = 0; m_cancel = 0; m_wins = 0;
      m_addr = '0; m_wdata = '0; m_we = 1'b0; m_wstrb = 4'h0;
      wait_cnt = 0; ev_if_done = 0; ev_d_done = 0;
   endtask

   // Called at posedge+1 with inputs applied; checks this cycle, advances the model.
   task automatic step();
      logic e_if_done, e_d_done;
      int   grant;
      #3;
      e_d_done  = mem_ack & m_busy & ~m_is_fetch;
      e_if_done = mem_ack & m_busy & m_is_fetch & ~m_cancel & ~if_flush;
      check("mem_req",   mem_req,   m_busy);
      check("mem_we",    mem_we,    m_we);
      check("mem_wstrb", mem_wstrb, m_wstrb);
      check("mem_addr",  mem_addr,  m_addr);
      check("mem_wdata", mem_wdata, m_wdata);
      check("if_done",   if_done,   e_if_done);
      check("d_done",    d_done,    e_d_done);
      check("stall_if",  stall_if,  if_req & ~e_if_done);
      check("stall_mem", stall_mem, d_req & ~e_d_done);
      check("if_rdata",  if_rdata,  mem_rdata);
      check("d_rdata",   d_rdata,   mem_rdata);
      check("starve",    dbg_starve, 64'(m_wins));
      s_mem_req = mem_req; s_if_done = if_done; s_d_done = d_done; s_mem_we = mem_we;
      s_mem_addr = mem_addr; s_if_rdata = if_rdata; s_mem_wstrb = mem_wstrb;
      s_starve = dbg_starve; s_state = dbg_state;
      grant = 0;
      if (m_busy) begin
         if (mem_ack) begin
            m_busy = 0; m_cancel = 0;
         end else if (m_is_fetch && if_flush) begin
            m_cancel = 1;
         end
      end else begin
         if (if_req && !if_flush && (!d_req || m_wins == LIMIT)) grant = 1;
         else if (d_req) grant = 2;
         if (grant == 1) begin
            m_busy = 1; m_is_fetch = 1; m_addr = if_addr;
            m_we = 0; m_wstrb = 4'h0; m_wdata = '0; m_wins = 0;
         end else if (grant == 2) begin
            m_busy = 1; m_is_fetch = 0; m_addr = d_addr; m_we = d_we;
            m_wstrb = d_we ? d_wstrb : 4'h0; m_wdata = d_wdata;
            if (if_req) m_wins = (m_wins < LIMIT) ? m_wins + 1 : LIMIT;
         end
         if (grant != 0) wait_cnt = mem_lat;
      end
      ev_if_done = e_if_done;
      ev_d_done  = e_d_done;
      @(posedge clk);
      #1;
   endtask

   // One cycle with the memory responder and the requesters' drop-on-done rule.
   task automatic cycle();
      mem_ack = 1'b0;
      if (m_busy) begin
         if (wait_cnt == 0) begin
            mem_ack = 1'b1; mem_rdata = ack_data;
         end else begin
            wait_cnt--;
         end
      end else if (spurious_en && $urandom_range(0, 15) == 0) begin
         mem_ack = 1'b1; mem_rdata = ack_data;
      end
      step();
      if_flush = 1'b0;
      mem_ack  = 1'b0;
      if (ev_if_done) if_req = 1'b0;
      if (ev_d_done)  d_req  = 1'b0;
   endtask

   initial begin
      int              n_a, n_b, cyc, max_st;
      logic [XLEN-1:0] a1, a2, rd;
      logic [3:0]      w1, w2;
      logic            prev_req, we1;
      bit              flush_now, got_fetch;

      reset = 1'b0; if_req = 0; if_flush = 0; d_req = 0; d_we = 0; mem_ack = 0;
      if_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = 4'h0; mem_rdata = '0;
      model_reset(); mem_lat = 0; ack_data = '0; spurious_en = 0;
      repeat (2) @(posedge clk);
      #3;
      check("rst_mem_req",   mem_req,   0);
      check("rst_mem_we",    mem_we,    0);
      check("rst_mem_wstrb", mem_wstrb, 0);
      check("rst_mem_addr",  mem_addr,  0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_if_done",   if_done,   0);
      check("rst_d_done",    d_done,    0);
      check("rst_state",     dbg_state, 0);
      check("rst_starve",    dbg_starve, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Single fetch, memory acks two cycles after mem_req rises.
      if_req = 1; if_addr = 32'h100; mem_lat = 2; ack_data = 32'h0050_0093;
      n_a = 0; cyc = 0; a1 = '0; we1 = 1'b1; rd = '0;
      for (int i = 1; i <= 12; i++) begin
         cycle();
         if (s_mem_req && a1 == '0) begin a1 = s_mem_addr; we1 = s_mem_we; end
         if (s_if_done) begin n_a++; rd = s_if_rdata; if (cyc == 0) cyc = i; end
      end
      check("t1_addr", a1, 32'h100);
      check("t1_we", we1, 0);
      check("t1_done_count", n_a, 1);
      check("t1_rdata", rd, 32'h0050_0093);
      check("t1_done_cycle", cyc, 4);

      // Store and fetch requested together: store first, fetch after one IDLE cycle.
      d_req = 1; d_we = 1; d_wstrb = 4'h3; d_addr = 32'h2000; d_wdata = 32'hBEEF;
      if_req = 1; if_addr = 32'h104; mem_lat = 0; ack_data = 32'h13;
      n_a = 0; prev_req = 0; cyc = 0; a1 = '0; a2 = '0; w1 = 4'h0; w2 = 4'hF;
      for (int i = 1; i <= 10; i++) begin
         cycle();
         if (s_mem_req && !prev_req) begin
            n_a++;
            if (n_a == 1) begin a1 = s_mem_addr; w1 = s_mem_wstrb; end
            if (n_a == 2) begin a2 = s_mem_addr; w2 = s_mem_wstrb; cyc = i; end
         end
         prev_req = s_mem_req;
      end
      check("t2_first_addr", a1, 32'h2000);
      check("t2_first_wstrb", w1, 4'h3);
      check("t2_second_addr", a2, 32'h104);
      check("t2_second_wstrb", w2, 4'h0);
      check("t2_fetch_cycle", cyc, 4);

      // Starvation: fetch held while data is re-requested after every d_done.
      if_req = 1; if_addr = 32'h200; d_we = 0; mem_lat = 0;
      n_a = 0; prev_req = 0; got_fetch = 0; max_st = 0; s_starve = 4'hF;
      for (int i = 0; i < 60 && !got_fetch; i++) begin
         if (!d_req) begin d_req = 1; d_addr = 32'h3000 + 32'(i * 4); end
         cycle();
         if (int'(s_starve) > max_st) max_st = int'(s_starve);
         if (s_mem_req && !prev_req) begin
            if (s_mem_addr == 32'h200) got_fetch = 1;
            else n_a++;
         end
         prev_req = s_mem_req;
      end
      check("t3_data_grants", n_a, LIMIT);
      check("t3_max_starve", max_st, LIMIT);
      check("t3_fetch_granted", got_fetch, 1);
      check("t3_starve_after", s_starve, 0);
      repeat (10) cycle();

      // Flush in the first cycle of a three-cycle fetch, then a new fetch.
      if_req = 1; if_addr = 32'h40; mem_lat = 2;
      n_a = 0; n_b = 0;
      for (int i = 1; i <= 8; i++) begin
         if (i == 2) if_flush = 1;
         cycle();
         if (i == 2) if_req = 0;
         if (s_mem_req) n_a++;
         if (s_if_done) n_b++;
      end
      check("t4_req_cycles", n_a, 3);
      check("t4_no_done", n_b, 0);
      if_req = 1; if_addr = 32'h80; n_b = 0; a1 = '0;
      for (int i = 1; i <= 8; i++) begin
         cycle();
         if (s_mem_req && a1 == '0) a1 = s_mem_addr;
         if (s_if_done) n_b++;
      end
      check("t4_next_addr", a1, 32'h80);
      check("t4_next_done", n_b, 1);

      // Flush on the very cycle memory acks the fetch.
      if_req = 1; if_addr = 32'h44; mem_lat = 1;
      for (int i = 0; i < 10 && !(m_busy && wait_cnt == 0); i++) cycle();
      if_flush = 1;
      cycle();
      if_req = 0;
      check("t5_if_done", s_if_done, 0);
      cycle();
      check("t5_req_low", s_mem_req, 0);
      check("t5_idle", s_state, 0);

      // Reset asserted while a store is on the bus.
      d_req = 1; d_we = 1; d_wstrb = 4'hF; d_addr = 32'h3000; d_wdata = 32'h1234_5678;
      mem_lat = 5;
      cycle();
      cycle();
      check("t6_busy", s_mem_req, 1);
      mem_ack = 1; reset = 0;
      #1;
      check("t6_mem_req", mem_req, 0);
      check("t6_mem_we", mem_we, 0);
      check("t6_mem_wstrb", mem_wstrb, 0);
      check("t6_mem_addr", mem_addr, 0);
      check("t6_mem_wdata", mem_wdata, 0);
      check("t6_d_done", d_done, 0);
      check("t6_state", dbg_state, 0);
      model_reset();
      mem_ack = 0;
      if_req = 1; if_addr = 32'h600; d_req = 1; d_we = 0; d_addr = 32'h500;
      @(posedge clk);
      #1;
      reset = 1;
      mem_lat = 0;
      cycle();
      cycle();
      check("t6_release_addr", s_mem_addr, 32'h500);
      check("t6_release_starve", s_starve, 1);
      repeat (8) cycle();

      // Random traffic against the model.
      spurious_en = 1;
      for (int i = 0; i < 4000; i++) begin
         if (!if_req && $urandom_range(0, 3) == 0) begin
            if_req = 1; if_addr = $urandom() & 32'hFFFF_FFFC;
         end
         if (!d_req && $urandom_range(0, 2) == 0) begin
            d_req = 1; d_we = 1'($urandom()); d_wstrb = 4'($urandom());
            d_addr = $urandom(); d_wdata = $urandom();
         end
         if_flush = ($urandom_range(0, 15) == 0);
         flush_now = if_flush;
         mem_lat = $urandom_range(0, 3);
         ack_data = $urandom();
         cycle();
         if (flush_now && $urandom_range(0, 1) == 1) if_req = 0;
      end

      $display("%0d/%0d checks passed", checks_pass, checks_total);
      $finish;
   end

endmodule
